// File: rtl/supply_responder.sv
// Responder end of the store restock handshake: accepts one request, prepares
// for a quantity-dependent time, deducts from a two-product stock and reports delivery.
module supply_responder #(
  parameter int unsigned PREP_BASE  = 2,
  parameter int unsigned PREP_SHIFT = 3,
  parameter logic [7:0]  STOCK_INIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic       product_in,
  input  logic [5:0] number_in,
  input  logic       refill_in,
  output logic       ready_out,
  output logic       done_out,
  output logic [5:0] delivered_out,
  output logic       short_out,
  output logic       proto_err_out,
  output logic [7:0] stock_a_out,
  output logic [7:0] stock_b_out
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [6:0] r_cnt;
  logic       r_product;
  logic [5:0] r_number;
  logic       r_ready;
  logic       r_done;
  logic [5:0] r_delivered;
  logic       r_short;
  logic       r_proto_err;
  logic [7:0] r_stock_a;
  logic [7:0] r_stock_b;

  logic       w_accept;
  logic       w_last_prep;
  logic [6:0] w_prep_len;
  logic [7:0] w_avail;
  logic [7:0] w_req;
  logic       w_short;
  logic [7:0] w_deliver;

  assign w_accept    = valid_in && r_ready;
  assign w_last_prep = (r_state == S_PREP) && (r_cnt == 7'd1);
  assign w_prep_len  = 7'(PREP_BASE) + {1'b0, number_in >> PREP_SHIFT};

  // A refill on the delivery edge lands first, so the deduction sees STOCK_INIT.
  assign w_avail   = refill_in ? STOCK_INIT : (r_product ? r_stock_a : r_stock_b);
  assign w_req     = {2'b00, r_number};
  assign w_short   = w_req > w_avail;
  assign w_deliver = w_short ? w_avail : w_req;

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)    w_state_next = S_PREP;
      S_PREP:  if (w_last_prep) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_product   <= 1'b0;
      r_number    <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_delivered <= '0;
      r_short     <= 1'b0;
      r_proto_err <= 1'b0;
      r_stock_a   <= STOCK_INIT;
      r_stock_b   <= STOCK_INIT;
    end else begin
      r_ready     <= (w_state_next == S_IDLE);
      r_done      <= w_last_prep;
      r_delivered <= w_last_prep ? w_deliver[5:0] : 6'd0;
      r_short     <= w_last_prep && w_short;

      if (valid_in && !r_ready) r_proto_err <= 1'b1;

      if (w_accept) begin
        r_product <= product_in;
        r_number  <= number_in;
        r_cnt     <= w_prep_len;
      end else if (r_state == S_PREP && r_cnt != 7'd0) begin
        r_cnt <= r_cnt - 7'd1;
      end

      if (refill_in) begin
        r_stock_a <= STOCK_INIT;
        r_stock_b <= STOCK_INIT;
      end
      if (w_last_prep) begin
        if (r_product) r_stock_a <= w_avail - w_deliver;
        else           r_stock_b <= w_avail - w_deliver;
      end
    end
  end

  assign ready_out     = r_ready;
  assign done_out      = r_done;
  assign delivered_out = r_delivered;
  assign short_out     = r_short;
  assign proto_err_out = r_proto_err;
  assign stock_a_out   = r_stock_a;
  assign stock_b_out   = r_stock_b;

endmodule

// File: tb/tb_supply_responder.sv
// Directed bench for supply_responder: expected deliveries are queued at request
// time from a small stock model and popped when done_out fires.
module tb_supply_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic       product_in = 1'b0;
  logic [5:0] number_in = 6'd0;
  logic       refill_in = 1'b0;
  logic       ready_out;
  logic       done_out;
  logic [5:0] delivered_out;
  logic       short_out;
  logic       proto_err_out;
  logic [7:0] stock_a_out;
  logic [7:0] stock_b_out;

  supply_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .product_in    (product_in),
    .number_in     (number_in),
    .refill_in     (refill_in),
    .ready_out     (ready_out),
    .done_out      (done_out),
    .delivered_out (delivered_out),
    .short_out     (short_out),
    .proto_err_out (proto_err_out),
    .stock_a_out   (stock_a_out),
    .stock_b_out   (stock_b_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int deliv;
    int short_f;
    int sa;
    int sb;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_a = 255;
  int   model_b = 255;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200 && ready_out !== 1'b1; i++) tick();
    check("ready_wait", 32'(ready_out), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready_out), 32'd0);
    check({tag, "_done"}, 32'(done_out), 32'd0);
    check({tag, "_deliv"}, 32'(delivered_out), 32'd0);
    check({tag, "_short"}, 32'(short_out), 32'd0);
    check({tag, "_proto"}, 32'(proto_err_out), 32'd0);
    check({tag, "_stock_a"}, 32'(stock_a_out), 32'd255);
    check({tag, "_stock_b"}, 32'(stock_b_out), 32'd255);
  endtask

  // One full handshake; optional refill on the final PREP edge and optional
  // illegal valid_in pulse during PREP.
  task automatic request(input bit prod, input int num, input bit do_refill, input bit do_proto);
    int   p;
    int   avail;
    int   d;
    exp_t e;
    exp_t got;
    wait_ready();
    p = 2 + (num >> 3);
    if (do_refill) begin
      model_a = 255;
      model_b = 255;
    end
    avail = prod ? model_a : model_b;
    d = (num < avail) ? num : avail;
    if (prod) model_a = model_a - d;
    else      model_b = model_b - d;
    e.deliv = d;
    e.short_f = (d < num) ? 1 : 0;
    e.sa = model_a;
    e.sb = model_b;
    sb_q.push_back(e);

    valid_in = 1'b1;
    product_in = prod;
    number_in = num[5:0];
    tick();
    valid_in = 1'b0;
    product_in = ~prod;
    number_in = ~number_in;
    for (int k = 1; k <= p; k++) begin
      if (do_proto && k == 3) begin
        valid_in = 1'b0;
        check("proto_set", 32'(proto_err_out), 32'd1);
      end
      check("prep_ready", 32'(ready_out), 32'd0);
      check("prep_done", 32'(done_out), 32'd0);
      if (do_proto && k == 2) begin
        valid_in = 1'b1;
        product_in = 1'b0;
        number_in = 6'd63;
      end
      if (do_refill && k == p) refill_in = 1'b1;
      tick();
      refill_in = 1'b0;
    end

    got = sb_q.pop_front();
    check("done_pulse", 32'(done_out), 32'd1);
    check("done_ready", 32'(ready_out), 32'd0);
    check("delivered", 32'(delivered_out), 32'(got.deliv));
    check("short", 32'(short_out), 32'(got.short_f));
    check("stock_a", 32'(stock_a_out), 32'(got.sa));
    check("stock_b", 32'(stock_b_out), 32'(got.sb));
    tick();
    check("post_done", 32'(done_out), 32'd0);
    check("post_deliv", 32'(delivered_out), 32'd0);
    check("post_short", 32'(short_out), 32'd0);
    check("post_ready", 32'(ready_out), 32'd1);
  endtask

  initial begin
    bit saw_done;

    // Reset state, then ready rises on the first edge after release.
    #12;
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    check("rel_ready_low", 32'(ready_out), 32'd0);
    tick();
    check("rel_ready_high", 32'(ready_out), 32'd1);

    // Basic delivery: A, 50 -> P=8, ready low 9 cycles.
    request(1'b1, 50, 1'b0, 1'b0);

    // Drain product B, then short deliveries.
    for (int i = 0; i < 5; i++) request(1'b0, 50, 1'b0, 1'b0);
    request(1'b0, 44, 1'b0, 1'b0);
    request(1'b0, 10, 1'b0, 1'b0);

    // Illegal valid during PREP is ignored but flagged.
    request(1'b1, 20, 1'b0, 1'b1);
    check("proto_sticky", 32'(proto_err_out), 32'd1);

    // Zero quantity.
    request(1'b1, 0, 1'b0, 1'b0);

    // Bring A down to 10, then refill on the final PREP edge.
    request(1'b1, 63, 1'b0, 1'b0);
    request(1'b1, 63, 1'b0, 1'b0);
    request(1'b1, 49, 1'b0, 1'b0);
    check("stock_a_ten", 32'(stock_a_out), 32'd10);
    request(1'b1, 40, 1'b1, 1'b0);
    check("proto_still", 32'(proto_err_out), 32'd1);

    // Reset mid-PREP: request lost, outputs back to reset values at once.
    wait_ready();
    valid_in = 1'b1;
    product_in = 1'b1;
    number_in = 6'd30;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_a = 255;
    model_b = 255;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 32'(ready_out), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done_out === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    check("midrst_stock_a", 32'(stock_a_out), 32'd255);

    // Normal operation after reset.
    request(1'b0, 8, 1'b0, 1'b0);
    check("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/supply_responder.md
Name: supply_responder

Overview:
- Responder end of the store restock handshake (kitchen or refrigerator side).
- Raises ready when idle and accepts one restock request (product select plus quantity) on valid&&ready.
- Spends a quantity-dependent preparation time, deducts the quantity from a two-product warehouse stock, then reports the delivered amount and re-raises ready.
- One instance sits behind each of the store's kitchen and refrigerator request channels.

Parameters:
PREP_BASE, 2, fixed preparation cycles per request (legal 1..15)
PREP_SHIFT, 3, one extra prep cycle per 2^PREP_SHIFT items (legal 0..5)
STOCK_INIT, 255, warehouse stock per product after reset/refill (8-bit)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  restock request strobe from store
product_in  input  1  product select (1 = product A, 0 = product B)
number_in  input  6  requested quantity, 0..63
refill_in  input  1  warehouse refill pulse
ready_out  output  1  responder idle, request may be accepted
done_out  output  1  one-cycle delivery complete pulse
delivered_out  output  6  quantity actually delivered, valid while done_out=1 (0 otherwise)
short_out  output  1  one-cycle pulse with done_out when delivery < request
proto_err_out  output  1  sticky: valid_in seen while ready_out=0
stock_a_out  output  8  warehouse stock, product A
stock_b_out  output  8  warehouse stock, product B

Behaviour:
- All outputs registered. Reset (async, any state including mid-PREP): state IDLE, ready_out=0, done_out=0, delivered_out=0, short_out=0, proto_err_out=0, stock_a/b=STOCK_INIT, internal latches cleared. Any in-flight request is lost.
- States: IDLE, PREP, DONE.
- IDLE:
  - ready_out=1 from the first cycle after reset release, and in every IDLE cycle thereafter.
  - Accept at the edge where valid_in=1 and ready_out=1.
  - On accept: latch product_in and number_in; load prep counter with P = PREP_BASE + (number_in >> PREP_SHIFT); go to PREP.
  - ready_out is 0 in the cycle immediately after the accept edge.
- PREP:
  - Lasts exactly P cycles; ready_out=0.
  - On the final PREP cycle's edge, go to DONE and compute delivery D = min(number, stock[product]) using 8-bit compare.
  - Register stock[product] -= D (never wraps below 0), delivered_out=D, done_out=1, and short_out=(D<number), all visible in the DONE cycle.
- DONE:
  - One cycle, ready_out=0; next state IDLE.
  - done_out, short_out and delivered_out return to 0 in the following cycle.
- Latency: ready_out is low for P+1 cycles after the accept edge, and done_out is high in the (P+1)th of those cycles.
  - Example: number=50, defaults → P=8, ready low 9 cycles.
- number_in=0: accepted normally, P=PREP_BASE, D=0, short_out=0.
- valid_in while ready_out=0: request ignored, state and stock unaffected, proto_err_out set and held until reset.
- refill_in:
  - Sets both stocks to STOCK_INIT at the edge, in any state.
  - If the refill coincides with the DONE-computing edge, the refill applies first and the deduction is taken from STOCK_INIT.
  - A refill during PREP affects D, since D is computed from stock at the final PREP edge.
- product_in and number_in are sampled only at the accept edge; changes afterwards have no effect.

Test Plan:
1. Reset, wait 1 cycle; valid_in=1, product=1, number=50 at ready → ready_out low 9 cycles, done_out=1 in the 9th with delivered_out=50, short_out=0, stock_a_out=205, stock_b_out=255.
2. Drain product B with 5×50 requests, then request number=44 (stock_b=5) → delivered_out=5, short_out=1, stock_b_out=0. A further request of 10 → delivered_out=0, short_out=1.
3. Assert valid_in during PREP (product=0, number=63) → proto_err_out=1 and stays 1; stock unchanged by that request; current delivery completes normally.
4. number=0 → ready low PREP_BASE+1=3 cycles, done_out=1, delivered_out=0, short_out=0.
5. With stock_a=10, request product=1, number=40 and pulse refill_in on the final PREP edge → delivered_out=40, short_out=0, stock_a_out=215.
6. Assert rst_n=0 mid-PREP → all outputs at reset values immediately, no done_out afterwards, ready_out=1 one cycle after release, stocks=255.
